// File: rtl/proc_feeder_if.sv
// ---------------------------------------------------------------------------
// proc_feeder_if
// Instruction handshake between the sequencer and the simple 9-bit processor.
//   DIN  : instruction or mvi immediate word (sequencer -> processor)
//   Run  : instruction-valid strobe          (sequencer -> processor)
//   Done : instruction complete, combinational in its own cycle
//          (processor -> sequencer)
// Modports: master = sequencer side, slave = processor side.
// ---------------------------------------------------------------------------
interface proc_feeder_if;
   logic [8:0] DIN;
   logic       Run;
   logic       Done;

   modport master (output DIN, output Run, input Done);
   modport slave  (input DIN, input Run, output Done);
endinterface

// File: rtl/proc_feeder.sv
// ---------------------------------------------------------------------------
// proc_feeder
// Instruction sequencer for the simple 9-bit processor. Holds a loadable
// 2^AW x 9 program memory and issues one instruction at a time, supplying
// the immediate word for mvi. An instruction retires on Done. Execution stops
// on a halt word, at the end of memory, or when Done fails to arrive within
// TMO cycles.
//
// Ports
//   Clock, Resetn     : rising-edge clock, asynchronous active-low reset
//   Start             : level; begins execution at address 0 when not busy
//   LdEn/LdAddr/LdData: program write port, honoured only when not busy
//   pbus (master)     : DIN/Run out to the processor, Done in
//   PC                : address of the current instruction
//   Busy/Halted/Err   : state decode (ISSUE|IMM|WAIT / HALT / ERR)
//   Retired           : completed-instruction count, wraps at 256
// ---------------------------------------------------------------------------
module proc_feeder #(
   parameter int AW  = 4,
   parameter int TMO = 8
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Start,
   input  logic                LdEn,
   input  logic [AW-1:0]       LdAddr,
   input  logic [8:0]          LdData,
   proc_feeder_if.master       pbus,
   output logic [AW-1:0]       PC,
   output logic                Busy,
   output logic                Halted,
   output logic                Err,
   output logic [7:0]          Retired
);

   localparam int              WD_W      = $clog2(TMO + 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TMO - 1);
   localparam logic [AW-1:0]   PC_LAST   = '1;
   localparam logic [AW-1:0]   PC_PENULT = PC_LAST - 1'b1;

   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_IMM,
      S_WAIT,
      S_HALT,
      S_ERR
   } state_t;

   state_t            state, state_n;
   logic [AW-1:0]     pc, pc_n;
   logic [7:0]        retired, retired_n;
   logic [WD_W-1:0]   wdog, wdog_n;
   logic [8:0]        din;
   logic              run;
   logic              ld_ok;

   logic [8:0]        mem [2**AW];
   logic [8:0]        inst;
   logic [8:0]        imm;
   logic [2:0]        op;

   // Combinational read; IMM fetches the word after the current mvi.
   assign inst = mem[pc];
   assign imm  = mem[pc + 1'b1];
   assign op   = inst[8:6];

   // Program store: no reset, writes locked out while an instruction is live.
   assign ld_ok = LdEn && (state == S_IDLE || state == S_HALT || state == S_ERR);

   always_ff @(posedge Clock) begin
      if (ld_ok) mem[LdAddr] <= LdData;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state   <= S_IDLE;
         pc      <= '0;
         retired <= '0;
         wdog    <= '0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         retired <= retired_n;
         wdog    <= wdog_n;
      end
   end

   // Done only steers next-state; Run and DIN decode registered state and
   // memory contents, so nothing loops back combinationally to the processor.
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      retired_n = retired;
      wdog_n    = wdog;
      din       = '0;
      run       = 1'b0;

      unique case (state)
         S_IDLE, S_HALT, S_ERR: begin
            if (Start) begin
               pc_n      = '0;
               retired_n = '0;
               state_n   = S_ISSUE;
            end
         end

         S_ISSUE: begin
            din    = inst;
            wdog_n = '0;
            if (op == OP_HALT) begin
               state_n = S_HALT;
            end else if (op == OP_MVI && pc == PC_LAST) begin
               // mvi with no room left for its immediate word.
               state_n = S_ERR;
            end else begin
               run     = 1'b1;
               state_n = (op == OP_MVI) ? S_IMM : S_WAIT;
            end
         end

         S_IMM: begin
            din = imm;
            if (pbus.Done) begin
               retired_n = retired + 8'd1;
               if (pc == PC_PENULT) state_n = S_HALT;
               else begin
                  pc_n    = pc + AW'(2);
                  state_n = S_ISSUE;
               end
            end else if (wdog == WD_LAST) begin
               state_n = S_ERR;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end

         S_WAIT: begin
            if (pbus.Done) begin
               retired_n = retired + 8'd1;
               if (pc == PC_LAST) state_n = S_HALT;
               else begin
                  pc_n    = pc + 1'b1;
                  state_n = S_ISSUE;
               end
            end else if (wdog == WD_LAST) begin
               state_n = S_ERR;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   // add/sub are not decoded separately: they simply stay longer in WAIT.
   logic unused_ops;
   assign unused_ops = (op == OP_ADD) || (op == OP_SUB);

   assign pbus.DIN  = din;
   assign pbus.Run  = run;
   assign PC        = pc;
   assign Retired   = retired;
   assign Busy      = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
   assign Halted    = (state == S_HALT);
   assign Err       = (state == S_ERR);

endmodule

// File: tb/tb_proc_feeder.sv
module tb_proc_feeder;

   localparam int AW  = 4;
   localparam int TMO = 8;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic          Start;
   logic          LdEn;
   logic [AW-1:0] LdAddr;
   logic [8:0]    LdData;
   logic [AW-1:0] PC;
   logic          Busy;
   logic          Halted;
   logic          Err;
   logic [7:0]    Retired;

   proc_feeder_if bus ();

   proc_feeder #(.AW(AW), .TMO(TMO)) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .Start   (Start),
      .LdEn    (LdEn),
      .LdAddr  (LdAddr),
      .LdData  (LdData),
      .pbus    (bus),
      .PC      (PC),
      .Busy    (Busy),
      .Halted  (Halted),
      .Err     (Err),
      .Retired (Retired)
   );

   always #5 Clock = ~Clock;

   // Processor stand-in: Done in T1 for mv/mvi, in T3 for add/sub.
   logic [1:0] pt;
   logic [2:0] pop;
   logic       done_en;
   logic       pdone;

   assign pdone    = done_en && ((pt == 2'd1 && !(pop == 3'b010 || pop == 3'b011)) ||
                                 (pt == 2'd3));
   assign bus.Done = pdone;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pt  <= 2'd0;
         pop <= 3'd0;
      end else if (pdone) begin
         pt <= 2'd0;
      end else if (bus.Run) begin
         pt  <= 2'd1;
         pop <= bus.DIN[8:6];
      end else if (pt != 2'd0) begin
         pt <= pt + 2'd1;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
      LdEn   = 1'b1;
      LdAddr = a;
      LdData = d;
      tick();
      LdEn   = 1'b0;
   endtask

   task automatic go();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   initial begin
      int runs;
      logic run_seen;

      Resetn  = 1'b0;
      Start   = 1'b0;
      LdEn    = 1'b0;
      LdAddr  = '0;
      LdData  = '0;
      done_en = 1'b1;
      #2;
      chk("rst_run",     bus.Run, 0);
      chk("rst_din",     bus.DIN, 0);
      chk("rst_pc",      PC, 0);
      chk("rst_busy",    Busy, 0);
      chk("rst_halted",  Halted, 0);
      chk("rst_err",     Err, 0);
      chk("rst_retired", Retired, 0);
      #10 Resetn = 1'b1;
      tick();

      // 1: basic program
      load(0, 9'h040); load(1, 9'h005); load(2, 9'h008);
      load(3, 9'h081); load(4, 9'h1C0);
      chk("idle_din", bus.DIN, 0);
      go();
      chk("t1_c1_run", bus.Run, 1);
      chk("t1_c1_din", bus.DIN, 9'h040);
      tick();
      chk("t1_c2_run", bus.Run, 0);
      chk("t1_c2_din", bus.DIN, 9'h005);
      tick();
      chk("t1_c3_run", bus.Run, 1);
      chk("t1_c3_din", bus.DIN, 9'h008);
      tick();
      chk("t1_c4_run", bus.Run, 0);
      tick();
      chk("t1_c5_run", bus.Run, 1);
      chk("t1_c5_din", bus.DIN, 9'h081);
      tick(); tick(); tick(); tick();
      chk("t1_c9_halted", Halted, 0);
      chk("t1_c9_run",    bus.Run, 0);
      tick();
      chk("t1_c10_halted",  Halted, 1);
      chk("t1_c10_retired", Retired, 3);
      chk("t1_c10_pc",      PC, 4);
      chk("t1_c10_busy",    Busy, 0);

      // 2: missing Done -> watchdog
      load(0, 9'h008);
      done_en = 1'b0;
      go();
      chk("t2_c1_run", bus.Run, 1);
      run_seen = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         tick();
         run_seen |= bus.Run;
      end
      chk("t2_c9_err",  Err, 0);
      chk("t2_c9_busy", Busy, 1);
      tick();
      run_seen |= bus.Run;
      chk("t2_c10_err",  Err, 1);
      chk("t2_norun",    run_seen, 0);
      done_en = 1'b1;

      // 3: mvi at last address
      for (int a = 0; a < 15; a++) load(AW'(a), 9'h008);
      load(15, 9'h040);
      go();
      runs = 0;
      for (int c = 1; c <= 31; c++) begin
         if (c > 1) tick();
         runs += int'(bus.Run);
      end
      chk("t3_runs",    runs, 15);
      chk("t3_run15",   bus.Run, 0);
      chk("t3_pc",      PC, 15);
      chk("t3_retired", Retired, 15);
      chk("t3_err_pre", Err, 0);
      tick();
      chk("t3_err",     Err, 1);

      // 4: wrap to HALT
      load(15, 9'h008);
      go();
      runs = 0;
      for (int c = 1; c <= 32; c++) begin
         if (c > 1) tick();
         runs += int'(bus.Run);
      end
      chk("t4_runs",       runs, 16);
      chk("t4_halted_pre", Halted, 0);
      tick();
      chk("t4_halted",  Halted, 1);
      chk("t4_retired", Retired, 16);
      chk("t4_pc",      PC, 15);

      // 5: reset during add T2, then restart
      load(2, 9'h081); load(3, 9'h1C0);
      go();
      for (int c = 2; c <= 7; c++) tick();
      chk("t5_c7_busy", Busy, 1);
      chk("t5_c7_pc",   PC, 2);
      #1 Resetn = 1'b0;
      #1;
      chk("t5_rst_run",     bus.Run, 0);
      chk("t5_rst_busy",    Busy, 0);
      chk("t5_rst_pc",      PC, 0);
      chk("t5_rst_retired", Retired, 0);
      #2 Resetn = 1'b1;
      tick();
      chk("t5_idle_busy",   Busy, 0);
      chk("t5_idle_halted", Halted, 0);
      go();
      chk("t5_c1_run", bus.Run, 1);
      chk("t5_c1_din", bus.DIN, 9'h008);
      for (int c = 2; c <= 10; c++) tick();
      chk("t5_halted",  Halted, 1);
      chk("t5_retired", Retired, 3);
      chk("t5_pc",      PC, 3);

      // 6: load/start interlock while busy
      Start = 1'b1;
      tick();
      LdEn   = 1'b1;
      LdAddr = 3;
      LdData = 9'h008;
      tick(); tick(); tick(); tick();
      chk("t6_c5_run", bus.Run, 1);
      chk("t6_c5_din", bus.DIN, 9'h081);
      chk("t6_c5_pc",  PC, 2);
      tick(); tick(); tick();
      Start = 1'b0;
      LdEn  = 1'b0;
      tick();
      chk("t6_c9_din", bus.DIN, 9'h1C0);
      chk("t6_c9_run", bus.Run, 0);
      tick();
      chk("t6_halted",  Halted, 1);
      chk("t6_retired", Retired, 3);
      chk("t6_pc",      PC, 3);

      // write in HALT is visible on the next Start
      load(2, 9'h1C0);
      go();
      chk("t6b_c1_din", bus.DIN, 9'h008);
      tick(); tick(); tick(); tick();
      chk("t6b_c5_din", bus.DIN, 9'h1C0);
      chk("t6b_c5_run", bus.Run, 0);
      tick();
      chk("t6b_halted",  Halted, 1);
      chk("t6b_retired", Retired, 2);
      chk("t6b_pc",      PC, 2);

      // write to address 0 and Start in the same cycle
      LdEn   = 1'b1;
      LdAddr = 0;
      LdData = 9'h1C0;
      Start  = 1'b1;
      tick();
      LdEn  = 1'b0;
      Start = 1'b0;
      chk("t6c_busy", Busy, 1);
      chk("t6c_din",  bus.DIN, 9'h1C0);
      chk("t6c_run",  bus.Run, 0);
      tick();
      chk("t6c_halted",  Halted, 1);
      chk("t6c_retired", Retired, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
